score_bcd_counter: RTL and testbench

- Per-player round-win counter. Counts rising edges of the game FSM's win indication and holds the score as two packed BCD digits.
- Each digit drives one seven-segment decoder (ones digit to HEX0 decoder, tens digit to HEX1 decoder).
- Asserts game_over when the score reaches the match target, then freezes until cleared.
- Sits between the tug-of-war playfield FSM and the HEX display decoders; one instance per player.

---
 rtl/score_bcd_counter.sv | 112 +++++++++++
 tb/tb_score_bcd_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - per-player BCD round-win counter with game-over freeze
// Optional build macro: SCORE_WIN_SYNC_EN (two-flop synchronizer on win).
module score_bcd_counter #(
  parameter int WIN_TARGET = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win,
  input  logic       clear,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       game_over,
  output logic       win_ack
);

  generate
    if (WIN_TARGET < 1 || WIN_TARGET > 99) begin : g_bad_target
      $error("score_bcd_counter: WIN_TARGET must be within 1..99");
    end
  endgenerate

  localparam logic [3:0] TGT_ONES = 4'(WIN_TARGET % 10);
  localparam logic [3:0] TGT_TENS = 4'(WIN_TARGET / 10);

  typedef enum logic {
    COUNTING = 1'b0,
    DONE     = 1'b1
  } state_t;

  state_t     state, state_n;
  logic [3:0] ones_n, tens_n;
  logic [3:0] ones_inc, tens_inc;
  logic       ack_n;
  logic       win_s;
  logic       win_prev;
  logic       win_rise;

`ifdef SCORE_WIN_SYNC_EN
  logic win_meta, win_sync;

  // Flops reset high so a win already asserted at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_meta <= 1'b1;
      win_sync <= 1'b1;
    end else begin
      win_meta <= win;
      win_sync <= win_meta;
    end
  end

  assign win_s = win_sync;
`else
  assign win_s = win;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_prev <= 1'b1;
    end else begin
      win_prev <= win_s;
    end
  end

  assign win_rise = win_s & ~win_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= COUNTING;
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      win_ack  <= 1'b0;
    end else begin
      state    <= state_n;
      bcd_ones <= ones_n;
      bcd_tens <= tens_n;
      win_ack  <= ack_n;
    end
  end

  always_comb begin
    ones_inc = bcd_ones + 4'd1;
    tens_inc = bcd_tens;
    if (bcd_ones == 4'd9) begin
      ones_inc = 4'd0;
      tens_inc = bcd_tens + 4'd1;
    end
  end

  // clear outranks a coincident edge; DONE ignores edges until clear or reset.
  always_comb begin
    state_n = state;
    ones_n  = bcd_ones;
    tens_n  = bcd_tens;
    ack_n   = 1'b0;
    if (clear) begin
      state_n = COUNTING;
      ones_n  = 4'd0;
      tens_n  = 4'd0;
    end else if (state == COUNTING && win_rise) begin
      ones_n = ones_inc;
      tens_n = tens_inc;
      ack_n  = 1'b1;
      if (ones_inc == TGT_ONES && tens_inc == TGT_TENS) begin
        state_n = DONE;
      end
    end
  end

  assign game_over = (state == DONE);

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb/tb_score_bcd_counter.sv - randomized and directed checks of score_bcd_counter against an integer score model
module tb_score_bcd_counter;

`ifdef SCORE_WIN_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif
  localparam int LAT = SYNC ? 3 : 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       win = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] d_ones [2];
  logic [3:0] d_tens [2];
  logic       d_go   [2];
  logic       d_ack  [2];

  int checks = 0;
  int fails = 0;
  int ack_cnt [2] = '{0, 0};

  int tgt [2] = '{7, 25};
  int score [2];
  bit ack [2];
  bit d1, d2, prev;

  always #5 clk = ~clk;

  score_bcd_counter #(.WIN_TARGET(7)) dut7 (
    .clk(clk), .reset(reset), .win(win), .clear(clear),
    .bcd_ones(d_ones[0]), .bcd_tens(d_tens[0]), .game_over(d_go[0]), .win_ack(d_ack[0])
  );

  score_bcd_counter #(.WIN_TARGET(25)) dut25 (
    .clk(clk), .reset(reset), .win(win), .clear(clear),
    .bcd_ones(d_ones[1]), .bcd_tens(d_tens[1]), .game_over(d_go[1]), .win_ack(d_ack[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: the score is a plain integer; a counted round is a rising edge of win (optionally delayed two clocks).
  always @(posedge clk or negedge reset) begin
    bit eff, rise;
    if (!reset) begin
      d1 = 1'b1;
      d2 = 1'b1;
      prev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        score[i] = 0;
        ack[i] = 1'b0;
      end
    end else begin
      eff = SYNC ? d2 : win;
      rise = eff && !prev;
      prev = eff;
      d2 = d1;
      d1 = win;
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          score[i] = 0;
          ack[i] = 1'b0;
        end else if (rise && score[i] < tgt[i]) begin
          score[i] = score[i] + 1;
          ack[i] = 1'b1;
        end else begin
          ack[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("ones[%0d]", i), d_ones[i], score[i] % 10);
        check($sformatf("tens[%0d]", i), d_tens[i], score[i] / 10);
        check($sformatf("game_over[%0d]", i), d_go[i], (score[i] == tgt[i]) ? 1 : 0);
        check($sformatf("win_ack[%0d]", i), d_ack[i], ack[i] ? 1 : 0);
        if (d_ack[i]) ack_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      win = 1'b1;
      tick(3);
      win = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    int base7, base25, edges;

    tick(2);
    #1;
    check("reset_ones", d_ones[0], 0);
    check("reset_go", d_go[0], 0);
    check("reset_ack", d_ack[0], 0);
    tick(1);
    reset = 1'b1;
    base7 = ack_cnt[0];
    tick(10);
    check("held_win_score", d_ones[0], 0);
    check("held_win_acks", ack_cnt[0] - base7, 0);
    win = 1'b0;
    tick(2);

    base7 = ack_cnt[0];
    pulses(7);
    tick(2);
    check("t7_ones", d_ones[0], 7);
    check("t7_tens", d_tens[0], 0);
    check("t7_go", d_go[0], 1);
    check("t7_acks", ack_cnt[0] - base7, 7);

    base7 = ack_cnt[0];
    pulses(3);
    tick(2);
    check("done_hold_ones", d_ones[0], 7);
    check("done_no_ack", ack_cnt[0] - base7, 0);
    check("t25_ones_at10", d_ones[1], 0);
    check("t25_tens_at10", d_tens[1], 1);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    check("clear_ones", d_ones[0], 0);
    check("clear_go", d_go[0], 0);

    base25 = ack_cnt[1];
    pulses(25);
    tick(2);
    check("t25_ones", d_ones[1], 5);
    check("t25_tens", d_tens[1], 2);
    check("t25_go", d_go[1], 1);
    check("t25_acks", ack_cnt[1] - base25, 25);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    pulses(3);
    tick(2);
    check("pre_clash_ones", d_ones[0], 3);
    win = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(5);
`ifndef SCORE_WIN_SYNC_EN
    check("clash_ones", d_ones[0], 0);
    check("clash_ack", d_ack[0], 0);
`endif
    win = 1'b0;
    tick(2);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    pulses(4);
    tick(2);
    check("pre_reset_ones", d_ones[0], 4);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_ones", d_ones[0], 0);
    check("async_reset_ones25", d_ones[1], 0);
    check("async_reset_go", d_go[0], 0);
    tick(1);
    reset = 1'b1;
    tick(3);

    win = 1'b1;
    edges = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (d_ones[0] == 4'd1) break;
    end
    check("win_latency_edges", edges, LAT);
    tick(1);
    win = 1'b0;
    tick(3);

    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) win = ~win;
      clear = ($urandom_range(0, 39) == 0);
    end
    clear = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
